// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (IFU/LSU) round-robin arbiter onto a single memory port
// One transaction outstanding at a time; responses time out after 2^TO_W-1 WAIT cycles.
module mem_arbiter #(
  parameter int TO_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [63:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [63:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [63:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [63:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  // Last WAIT cycle before the counter would reach 2^TO_W-1.
  localparam logic [TO_W-1:0] CNT_LAST = TO_W'((1 << TO_W) - 2);

  state_t          state;
  logic            owner;       // 1 = LSU
  logic            last_owner;  // 1 = LSU
  logic            addr_hi;
  logic [TO_W-1:0] cnt;
  logic            pick_lsu;
  logic            can_accept;
  logic            timeout;
  logic            unused_addr;

  assign unused_addr = &{1'b0, ifu_addr[1:0]};

  // The response-pulse cycle is IDLE too, but acceptance waits one more cycle.
  assign can_accept    = !rst && (state == IDLE) && !ifu_resp_valid && !lsu_resp_valid;
  assign pick_lsu      = lsu_req_valid && (!ifu_req_valid || !last_owner);
  assign lsu_req_ready = can_accept && pick_lsu;
  assign ifu_req_ready = can_accept && ifu_req_valid && !pick_lsu;
  assign timeout       = !mem_resp_valid && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      owner          <= 1'b0;
      last_owner     <= 1'b0;
      addr_hi        <= 1'b0;
      cnt            <= '0;
      mem_req_valid  <= 1'b0;
      mem_addr       <= '0;
      mem_wen        <= 1'b0;
      mem_wdata      <= '0;
      mem_wmask      <= '0;
      ifu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      ifu_err        <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_rdata      <= '0;
      lsu_err        <= 1'b0;
    end else begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      ifu_err        <= 1'b0;
      lsu_err        <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu_req_ready) begin
            state         <= REQ;
            mem_req_valid <= 1'b1;
            owner         <= 1'b1;
            last_owner    <= 1'b1;
            mem_addr      <= lsu_addr;
            mem_wen       <= lsu_wen;
            mem_wdata     <= lsu_wdata;
            mem_wmask     <= lsu_wmask;
          end else if (ifu_req_ready) begin
            state         <= REQ;
            mem_req_valid <= 1'b1;
            owner         <= 1'b0;
            last_owner    <= 1'b0;
            mem_addr      <= {ifu_addr[63:3], 3'b000};
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            addr_hi       <= ifu_addr[2];
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state         <= WAIT;
            mem_req_valid <= 1'b0;
            cnt           <= '0;
          end
        end
        WAIT: begin
          if (mem_resp_valid || timeout) begin
            state <= IDLE;
            if (owner) begin
              lsu_resp_valid <= 1'b1;
              lsu_err        <= timeout;
              lsu_rdata      <= (mem_resp_valid && !mem_wen) ? mem_rdata : 64'd0;
            end else begin
              ifu_resp_valid <= 1'b1;
              ifu_err        <= timeout;
              if (!mem_resp_valid)
                ifu_rdata <= '0;
              else
                ifu_rdata <= addr_hi ? mem_rdata[63:32] : mem_rdata[31:0];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
